// File: rtl/ps2_paddle_keys.sv
// ps2_paddle_keys
//   Scancode-set-2 decoder for the Pong paddle keys. Consumes the byte stream
//   from PS2_Controller, tracks E0/F0 prefixes, keeps per-key held flags and
//   derives paddle commands, the last make byte, key events and protocol errors.
//
// Ports
//   CLOCK_50          in   system clock, rising edge
//   reset             in   synchronous, active-high
//   received_data     in   [7:0] byte from PS2_Controller
//   received_data_en  in   one-cycle strobe qualifying received_data
//   key_held          out  [3:0] bit0 W, bit1 S, bit2 Up, bit3 Down
//   l_up/l_dn/r_up/r_dn out paddle commands (conflicting keys cancel)
//   last_make         out  [7:0] final byte of the most recent make sequence
//   event_valid       out  one-cycle pulse when a key_held bit toggles
//   event_key         out  [1:0] index of the toggled key
//   event_break       out  1 = release, 0 = press
//   proto_err         out  one-cycle pulse on malformed prefix or timeout
//
// state     | meaning
// ----------+--------------------------------------------
// S_IDLE    | no prefix pending
// S_EXT     | E0 seen, waiting for extended code or F0
// S_BRK     | F0 seen, waiting for non-extended break code
// S_EXT_BRK | E0 F0 seen, waiting for extended break code

module ps2_paddle_keys #(
    parameter logic [7:0] KEY_W          = 8'h1D,
    parameter logic [7:0] KEY_S          = 8'h1B,
    parameter logic [7:0] KEY_UP         = 8'h75,
    parameter logic [7:0] KEY_DN         = 8'h72,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic [3:0] key_held,
    output logic       l_up,
    output logic       l_dn,
    output logic       r_up,
    output logic       r_dn,
    output logic [7:0] last_make,
    output logic       event_valid,
    output logic [1:0] event_key,
    output logic       event_break,
    output logic       proto_err
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    // Loaded with T-1 so that terminal count 1 lands the error pulse exactly
    // TIMEOUT_CYCLES cycles after the last accepted byte.
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_FC = 8'hFC;

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic [3:0]    held_nxt;
    logic [7:0]    last_nxt;
    logic          ev_v_nxt, ev_b_nxt, err_nxt;
    logic [1:0]    ev_k_nxt;

    logic          reproc;
    logic          upd;
    logic [1:0]    upd_idx;
    logic          upd_val;
    logic          is_prefix;

    assign is_prefix = (received_data == BYTE_E0) || (received_data == BYTE_F0);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= S_IDLE;
            tmr         <= '0;
            key_held    <= '0;
            last_make   <= '0;
            event_valid <= 1'b0;
            event_key   <= '0;
            event_break <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            tmr         <= tmr_nxt;
            key_held    <= held_nxt;
            last_make   <= last_nxt;
            event_valid <= ev_v_nxt;
            event_key   <= ev_k_nxt;
            event_break <= ev_b_nxt;
            proto_err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        held_nxt  = key_held;
        last_nxt  = last_make;
        ev_v_nxt  = 1'b0;
        ev_k_nxt  = event_key;
        ev_b_nxt  = event_break;
        err_nxt   = 1'b0;
        reproc    = 1'b0;
        upd       = 1'b0;
        upd_idx   = 2'd0;
        upd_val   = 1'b0;

        if (received_data_en) begin
            tmr_nxt = TMR_LOAD;
            case (state)
                S_IDLE: reproc = 1'b1;
                S_EXT: begin
                    if (received_data == BYTE_F0) begin
                        state_nxt = S_EXT_BRK;
                    end else if (received_data == BYTE_E0) begin
                        state_nxt = S_EXT;
                    end else begin
                        state_nxt = S_IDLE;
                        last_nxt  = received_data;
                        if (received_data == KEY_UP) begin
                            upd = 1'b1; upd_idx = 2'd2; upd_val = 1'b1;
                        end else if (received_data == KEY_DN) begin
                            upd = 1'b1; upd_idx = 2'd3; upd_val = 1'b1;
                        end
                    end
                end
                S_BRK: begin
                    if (is_prefix) begin
                        err_nxt = 1'b1;
                        reproc  = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        if (received_data == KEY_W) begin
                            upd = 1'b1; upd_idx = 2'd0;
                        end else if (received_data == KEY_S) begin
                            upd = 1'b1; upd_idx = 2'd1;
                        end
                    end
                end
                S_EXT_BRK: begin
                    if (is_prefix) begin
                        err_nxt = 1'b1;
                        reproc  = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        if (received_data == KEY_UP) begin
                            upd = 1'b1; upd_idx = 2'd2;
                        end else if (received_data == KEY_DN) begin
                            upd = 1'b1; upd_idx = 2'd3;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase

            // Byte handled with IDLE semantics, either natively or after a
            // broken break prefix.
            if (reproc) begin
                if (received_data == BYTE_E0) begin
                    state_nxt = S_EXT;
                end else if (received_data == BYTE_F0) begin
                    state_nxt = S_BRK;
                end else begin
                    state_nxt = S_IDLE;
                    if (received_data == BYTE_AA || received_data == BYTE_FC) begin
                        held_nxt = '0;
                    end else begin
                        last_nxt = received_data;
                        if (received_data == KEY_W) begin
                            upd = 1'b1; upd_idx = 2'd0; upd_val = 1'b1;
                        end else if (received_data == KEY_S) begin
                            upd = 1'b1; upd_idx = 2'd1; upd_val = 1'b1;
                        end
                    end
                end
            end

            if (upd && (key_held[upd_idx] != upd_val)) begin
                held_nxt[upd_idx] = upd_val;
                ev_v_nxt          = 1'b1;
                ev_k_nxt          = upd_idx;
                ev_b_nxt          = ~upd_val;
            end
        end else if (state != S_IDLE) begin
            if (tmr == TW'(1)) begin
                state_nxt = S_IDLE;
                err_nxt   = 1'b1;
                tmr_nxt   = '0;
            end else begin
                tmr_nxt = tmr - TW'(1);
            end
        end
    end

    assign l_up = key_held[0] & ~key_held[1];
    assign l_dn = key_held[1] & ~key_held[0];
    assign r_up = key_held[2] & ~key_held[3];
    assign r_dn = key_held[3] & ~key_held[2];

endmodule
